mc_core_seq: RTL and testbench
==============================

Name: mc_core_seq

Overview:
- Multi-cycle sequencer for the MIPS core.
- Replaces single-cycle combinational control with an FSM that steps each instruction through FETCH/DECODE/EXEC/MEM/WB.
- Issues per-state datapath strobes and handshakes with a variable-latency memory via req/ready.
- Adds a memory-timeout fault, a sticky trap on illegal opcodes, and optional performance counters.

Parameters:
- MEM_TIMEOUT, 16: max cycles mem_req may stay unanswered before fault; legal 1..255.
- CNT_W, 32: width of performance counters.

Ports:
- clk  in  1  rising-edge clock
- reset  in  1  asynchronous, active-low reset
- opcode  in  6  IR[31:26] from instruction register
- funct  in  6  IR[5:0]
- zero  in  1  ALU equality flag
- mem_ready  in  1  memory completes current request this cycle
- mem_req  out  1  memory request, held until mem_ready
- mem_we  out  1  write qualifier for mem_req
- ir_we  out  1  load instruction register
- pc_we  out  1  update PC
- pc_sel  out  2  0 PC+4, 1 branch, 2 jump, 3 register
- reg_we  out  1  GPR write
- reg_dst  out  2  0 rt, 1 rd, 2 r31
- data_to_reg  out  2  0 ALU, 1 memory, 2 PC
- alu_src_b  out  1  0 register B, 1 extended immediate
- ext_op  out  1  0 zero-extend, 1 sign-extend
- alu_op  out  3  0 add, 1 sub, 2 or, 3 lui
- state  out  3  current FSM state
- fault  out  2  0 none, 1 illegal opcode, 2 memory timeout
- retired  out  CNT_W  instructions completed
- cycles  out  CNT_W  cycles since reset

Behaviour:
- Decoded instructions:
  - R-type (opcode 000000): addu funct 100001, subu funct 100011, jr funct 001000.
  - I/J-type: ori 001101, lui 001111, lw 100011, sw 101011, beq 000100, j 000010, jal 000011.
- State encoding: FETCH=0, DECODE=1, EXEC=2, MEM=3, WB=4, TRAP=7.
- State, timeout counter and perf counters are registered. All strobes are combinational from state, opcode, funct, zero and mem_ready.
- Reset: while reset=0, state=FETCH, fault=0, counters=0, and every strobe is forced 0. The first mem_req appears in the first cycle after reset deasserts.
- FETCH:
  - mem_req=1, mem_we=0.
  - On mem_ready: ir_we=1, pc_we=1, pc_sel=0, then go to DECODE.
- DECODE:
  - j: pc_we=1, pc_sel=2, then FETCH.
  - jal: pc_we=1, pc_sel=2, reg_we=1, reg_dst=2, data_to_reg=2, then FETCH.
  - Unknown opcode, or unknown funct under opcode 000000: fault=1, go to TRAP.
  - All others go to EXEC.
- EXEC:
  - addu/subu: alu_src_b=0, alu_op=0/1, then WB.
  - ori: alu_src_b=1, ext_op=0, alu_op=2, then WB.
  - lui: alu_src_b=1, alu_op=3, then WB.
  - lw/sw: alu_src_b=1, ext_op=1, alu_op=0, then MEM.
  - beq: alu_op=1; pc_we=zero, pc_sel=1; then FETCH.
  - jr: pc_we=1, pc_sel=3, then FETCH.
- MEM:
  - mem_req=1, mem_we=(sw).
  - On mem_ready: sw goes to FETCH, lw goes to WB.
- WB:
  - reg_we=1, then FETCH.
  - lw: data_to_reg=1, reg_dst=0.
  - R-type: reg_dst=1.
  - ori/lui: reg_dst=0.
  - data_to_reg=0 for all non-lw writes.
- Timeout:
  - Counter clears on entry to FETCH/MEM and on mem_ready; increments each cycle mem_req=1 and mem_ready=0.
  - When it reaches MEM_TIMEOUT with mem_ready still 0: fault=2, go to TRAP.
  - mem_ready on that same cycle wins; no fault is raised.
- TRAP: absorbing state. All strobes 0, fault held until reset.
- Ignored inputs: mem_ready outside FETCH/MEM has no effect; zero outside EXEC is ignored.
- Perf counters:
  - retired increments on the cycle an instruction's final state completes: the FETCH-return transition, with taken and not-taken beq both counted.
  - cycles increments every cycle outside TRAP.
  - Both wrap modulo 2^CNT_W.
- Reset mid-instruction aborts immediately; no strobe glitches after reset falls.

Optional Feature:
- PERF_CNT_EN defined: retired and cycles counters implemented as above.
- Undefined: no counter flops; retired and cycles tied to 0.

Test Plan:
- addu with mem_ready=1 every request -> states 0,1,2,4,0; reg_we=1 only in WB with reg_dst=1; retired=1 after 4 cycles.
- lw with mem_ready delayed 3 cycles in FETCH and 2 in MEM -> mem_req held throughout each wait; ir_we once; WB has data_to_reg=1; total 10 cycles.
- beq with zero=1, then zero=0 -> EXEC shows pc_we=1/pc_sel=1, then pc_we=0; both return to FETCH; retired=2.
- jal -> DECODE asserts pc_we, pc_sel=2, reg_we, reg_dst=2, data_to_reg=2; next state FETCH.
- Opcode 111111 -> fault=1, state=7, all strobes 0 for 20 cycles; reset low then high -> state=0, fault=0.
- MEM_TIMEOUT=4 with mem_ready stuck 0 in FETCH -> fault=2 exactly 4 cycles after entry; repeat with mem_ready on cycle 4 -> DECODE, no fault.

Source files
------------

// File: rtl/mc_core_seq.sv
// mc_core_seq: multi-cycle sequencer for the MIPS core.
//
// Each instruction is stepped through FETCH/DECODE/EXEC/MEM/WB. Per-state
// datapath strobes are decoded combinationally. Memory accesses use a
// req/ready handshake that is guarded by a timeout.
//
// Parameters:
//   MEM_TIMEOUT  cycles a request may stay unanswered before a fault (1..255)
//   CNT_W        width of the performance counters
//
// Ports:
//   i_clk, i_rst_n       clock; asynchronous active-low reset
//   i_opcode, i_funct    IR[31:26], IR[5:0]
//   i_zero               ALU equality flag (only used in EXEC)
//   i_mem_ready          memory completes the current request this cycle
//   o_mem_req, o_mem_we  memory request and write qualifier
//   o_ir_we, o_pc_we     IR load, PC update
//   o_pc_sel             0 PC+4, 1 branch, 2 jump, 3 register
//   o_reg_we, o_reg_dst  GPR write; destination 0 rt, 1 rd, 2 r31
//   o_data_to_reg        0 ALU, 1 memory, 2 PC
//   o_alu_src_b, o_ext_op, o_alu_op   ALU operand/extension/operation select
//   o_state, o_fault     FSM state; fault 0 none, 1 illegal, 2 mem timeout
//   o_retired, o_cycles  performance counters
//
// Optional feature macro: PERF_CNT_EN. When it is undefined, no counter
// flops exist and o_retired/o_cycles are tied to 0.

module mc_core_seq #(
    parameter int unsigned MEM_TIMEOUT = 16,
    parameter int unsigned CNT_W       = 32
) (
    input  logic             i_clk,
    input  logic             i_rst_n,
    input  logic [5:0]       i_opcode,
    input  logic [5:0]       i_funct,
    input  logic             i_zero,
    input  logic             i_mem_ready,
    output logic             o_mem_req,
    output logic             o_mem_we,
    output logic             o_ir_we,
    output logic             o_pc_we,
    output logic [1:0]       o_pc_sel,
    output logic             o_reg_we,
    output logic [1:0]       o_reg_dst,
    output logic [1:0]       o_data_to_reg,
    output logic             o_alu_src_b,
    output logic             o_ext_op,
    output logic [2:0]       o_alu_op,
    output logic [2:0]       o_state,
    output logic [1:0]       o_fault,
    output logic [CNT_W-1:0] o_retired,
    output logic [CNT_W-1:0] o_cycles
);

    typedef enum logic [2:0] {
        StFetch  = 3'd0,
        StDecode = 3'd1,
        StExec   = 3'd2,
        StMem    = 3'd3,
        StWb     = 3'd4,
        StTrap   = 3'd7
    } state_t;

    localparam logic [7:0] TMO_LAST = 8'(MEM_TIMEOUT - 1);

    state_t     r_state, w_state_d;
    logic [1:0] r_fault, w_fault_d;
    logic [7:0] r_tmo, w_tmo_d;
    logic       w_retire;

    logic w_mem_req, w_mem_we, w_ir_we, w_pc_we, w_reg_we, w_alu_src_b, w_ext_op;
    logic [1:0] w_pc_sel, w_reg_dst, w_data_to_reg;
    logic [2:0] w_alu_op;

    // Instruction decode
    logic w_is_r, w_addu, w_subu, w_jr, w_ori, w_lui, w_lw, w_sw, w_beq, w_j, w_jal, w_legal;
    assign w_is_r  = (i_opcode == 6'b000000);
    assign w_addu  = w_is_r && (i_funct == 6'b100001);
    assign w_subu  = w_is_r && (i_funct == 6'b100011);
    assign w_jr    = w_is_r && (i_funct == 6'b001000);
    assign w_ori   = (i_opcode == 6'b001101);
    assign w_lui   = (i_opcode == 6'b001111);
    assign w_lw    = (i_opcode == 6'b100011);
    assign w_sw    = (i_opcode == 6'b101011);
    assign w_beq   = (i_opcode == 6'b000100);
    assign w_j     = (i_opcode == 6'b000010);
    assign w_jal   = (i_opcode == 6'b000011);
    assign w_legal = w_addu | w_subu | w_jr | w_ori | w_lui | w_lw | w_sw | w_beq | w_j | w_jal;

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_state <= StFetch;
            r_fault <= 2'd0;
            r_tmo   <= 8'd0;
        end else begin
            r_state <= w_state_d;
            r_fault <= w_fault_d;
            r_tmo   <= w_tmo_d;
        end
    end

    always_comb begin
        w_state_d     = r_state;
        w_fault_d     = r_fault;
        w_tmo_d       = 8'd0;      // zero outside FETCH/MEM, so entry always starts clean
        w_retire      = 1'b0;
        w_mem_req     = 1'b0;
        w_mem_we      = 1'b0;
        w_ir_we       = 1'b0;
        w_pc_we       = 1'b0;
        w_pc_sel      = 2'd0;
        w_reg_we      = 1'b0;
        w_reg_dst     = 2'd0;
        w_data_to_reg = 2'd0;
        w_alu_src_b   = 1'b0;
        w_ext_op      = 1'b0;
        w_alu_op      = 3'd0;
        unique case (r_state)
            StFetch: begin
                w_mem_req = 1'b1;
                if (i_mem_ready) begin
                    w_ir_we   = 1'b1;
                    w_pc_we   = 1'b1;
                    w_state_d = StDecode;
                end else if (r_tmo == TMO_LAST) begin
                    w_fault_d = 2'd2;
                    w_state_d = StTrap;
                end else begin
                    w_tmo_d = r_tmo + 8'd1;
                end
            end
            StDecode: begin
                if (w_j || w_jal) begin
                    w_pc_we   = 1'b1;
                    w_pc_sel  = 2'd2;
                    w_state_d = StFetch;
                    w_retire  = 1'b1;
                    if (w_jal) begin
                        w_reg_we      = 1'b1;
                        w_reg_dst     = 2'd2;
                        w_data_to_reg = 2'd2;
                    end
                end else if (!w_legal) begin
                    w_fault_d = 2'd1;
                    w_state_d = StTrap;
                end else begin
                    w_state_d = StExec;
                end
            end
            StExec: begin
                w_state_d = StWb;
                if (w_subu) begin
                    w_alu_op = 3'd1;
                end else if (w_ori) begin
                    w_alu_src_b = 1'b1;
                    w_alu_op    = 3'd2;
                end else if (w_lui) begin
                    w_alu_src_b = 1'b1;
                    w_alu_op    = 3'd3;
                end else if (w_lw || w_sw) begin
                    w_alu_src_b = 1'b1;
                    w_ext_op    = 1'b1;
                    w_state_d   = StMem;
                end else if (w_beq) begin
                    w_alu_op  = 3'd1;
                    w_pc_we   = i_zero;
                    w_pc_sel  = 2'd1;
                    w_state_d = StFetch;
                    w_retire  = 1'b1;
                end else if (w_jr) begin
                    w_pc_we   = 1'b1;
                    w_pc_sel  = 2'd3;
                    w_state_d = StFetch;
                    w_retire  = 1'b1;
                end else if (!w_addu) begin
                    // IR changed under us; restart rather than write back garbage
                    w_state_d = StFetch;
                end
            end
            StMem: begin
                w_mem_req = 1'b1;
                w_mem_we  = w_sw;
                if (i_mem_ready) begin
                    w_state_d = w_sw ? StFetch : StWb;
                    w_retire  = w_sw;
                end else if (r_tmo == TMO_LAST) begin
                    w_fault_d = 2'd2;
                    w_state_d = StTrap;
                end else begin
                    w_tmo_d = r_tmo + 8'd1;
                end
            end
            StWb: begin
                w_reg_we      = 1'b1;
                w_reg_dst     = w_is_r ? 2'd1 : 2'd0;
                w_data_to_reg = w_lw ? 2'd1 : 2'd0;
                w_state_d     = StFetch;
                w_retire      = 1'b1;
            end
            StTrap: begin
                w_state_d = StTrap;
            end
            default: begin
                w_state_d = StFetch;
            end
        endcase
    end

    // Strobes are gated by reset so nothing is driven while reset is held.
    assign o_mem_req     = i_rst_n & w_mem_req;
    assign o_mem_we      = i_rst_n & w_mem_we;
    assign o_ir_we       = i_rst_n & w_ir_we;
    assign o_pc_we       = i_rst_n & w_pc_we;
    assign o_pc_sel      = i_rst_n ? w_pc_sel : 2'd0;
    assign o_reg_we      = i_rst_n & w_reg_we;
    assign o_reg_dst     = i_rst_n ? w_reg_dst : 2'd0;
    assign o_data_to_reg = i_rst_n ? w_data_to_reg : 2'd0;
    assign o_alu_src_b   = i_rst_n & w_alu_src_b;
    assign o_ext_op      = i_rst_n & w_ext_op;
    assign o_alu_op      = i_rst_n ? w_alu_op : 3'd0;
    assign o_state       = r_state;
    assign o_fault       = r_fault;

`ifdef PERF_CNT_EN
    logic [CNT_W-1:0] r_retired, r_cycles;

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_retired <= '0;
            r_cycles  <= '0;
        end else begin
            if (w_retire) begin
                r_retired <= r_retired + CNT_W'(1);
            end
            if (r_state != StTrap) begin
                r_cycles <= r_cycles + CNT_W'(1);
            end
        end
    end

    assign o_retired = r_retired;
    assign o_cycles  = r_cycles;
`else
    logic w_unused_retire;
    assign w_unused_retire = w_retire;
    assign o_retired       = '0;
    assign o_cycles        = '0;
`endif

endmodule

// File: tb/tb_mc_core_seq.sv
// Scoreboard bench for mc_core_seq (MEM_TIMEOUT=4). The driver pushes the
// hand-computed strobe vector for every cycle; a negedge monitor pops and
// compares. Counter expectations follow PERF_CNT_EN.

module tb_mc_core_seq;

    localparam int unsigned CNT_W = 32;

    logic             clk = 1'b0;
    logic             rst_n = 1'b0;
    logic [5:0]       opcode = 6'd0;
    logic [5:0]       funct = 6'd0;
    logic             zero = 1'b0;
    logic             mem_ready = 1'b0;
    logic             mem_req, mem_we, ir_we, pc_we, reg_we, alu_src_b, ext_op;
    logic [1:0]       pc_sel, reg_dst, data_to_reg, fault;
    logic [2:0]       alu_op, state;
    logic [CNT_W-1:0] retired, cycles;

    mc_core_seq #(
        .MEM_TIMEOUT(4),
        .CNT_W      (CNT_W)
    ) dut (
        .i_clk        (clk),
        .i_rst_n      (rst_n),
        .i_opcode     (opcode),
        .i_funct      (funct),
        .i_zero       (zero),
        .i_mem_ready  (mem_ready),
        .o_mem_req    (mem_req),
        .o_mem_we     (mem_we),
        .o_ir_we      (ir_we),
        .o_pc_we      (pc_we),
        .o_pc_sel     (pc_sel),
        .o_reg_we     (reg_we),
        .o_reg_dst    (reg_dst),
        .o_data_to_reg(data_to_reg),
        .o_alu_src_b  (alu_src_b),
        .o_ext_op     (ext_op),
        .o_alu_op     (alu_op),
        .o_state      (state),
        .o_fault      (fault),
        .o_retired    (retired),
        .o_cycles     (cycles)
    );

    always #5 clk = ~clk;

    typedef struct {
        string            name;
        logic [20:0]      vec;
        logic [CNT_W-1:0] ret;
        logic [CNT_W-1:0] cyc;
    } exp_t;

    exp_t    sb[$];
    exp_t    mon_it;
    int      checks = 0;
    int      errors = 0;
    logic [5:0] cur_op = 6'd0;
    logic [5:0] cur_fn = 6'd0;
    int unsigned ret_m = 0;
    int unsigned cyc_m = 0;

    // {state, fault, req, we, ir_we, pc_we, pc_sel, reg_we, reg_dst, d2r, asb, ext, alu_op}
    function automatic logic [20:0] ev(input logic [2:0] st, input logic [1:0] flt,
                                       input logic rq, input logic mwe, input logic irw,
                                       input logic pcw, input logic [1:0] pcs, input logic rw,
                                       input logic [1:0] rd, input logic [1:0] dr,
                                       input logic asb, input logic ext, input logic [2:0] aop);
        return {st, flt, rq, mwe, irw, pcw, pcs, rw, rd, dr, asb, ext, aop};
    endfunction

    logic [20:0] v_fw, v_fd, v_dec;

    task automatic load(input logic [5:0] op, input logic [5:0] fn);
        cur_op = op;
        cur_fn = fn;
    endtask

    task automatic push(input string nm, input logic [20:0] v);
        exp_t it;
        it.name = nm;
        it.vec  = v;
`ifdef PERF_CNT_EN
        it.ret = CNT_W'(ret_m);
        it.cyc = CNT_W'(cyc_m);
`else
        it.ret = '0;
        it.cyc = '0;
`endif
        sb.push_back(it);
    endtask

    task automatic step(input string nm, input logic rdy, input logic z, input logic [20:0] v,
                        input bit ret);
        opcode    = cur_op;
        funct     = cur_fn;
        mem_ready = rdy;
        zero      = z;
        push(nm, v);
        @(posedge clk);
        #1;
        if (ret) ret_m++;
        if (v[20:18] != 3'd7) cyc_m++;
    endtask

    task automatic rstep(input string nm);
        rst_n     = 1'b0;
        mem_ready = 1'b1;
        ret_m     = 0;
        cyc_m     = 0;
        push(nm, 21'd0);
        @(posedge clk);
        #1;
    endtask

    always @(negedge clk) begin
        if (sb.size() > 0) begin
            mon_it = sb.pop_front();
            checks++;
            if ({state, fault, mem_req, mem_we, ir_we, pc_we, pc_sel, reg_we, reg_dst,
                 data_to_reg, alu_src_b, ext_op, alu_op} !== mon_it.vec) begin
                errors++;
                $display("FAIL %s: outputs got %b required %b", mon_it.name,
                         {state, fault, mem_req, mem_we, ir_we, pc_we, pc_sel, reg_we,
                          reg_dst, data_to_reg, alu_src_b, ext_op, alu_op}, mon_it.vec);
            end
            checks++;
            if (retired !== mon_it.ret) begin
                errors++;
                $display("FAIL %s retired: got %0d required %0d", mon_it.name, retired,
                         mon_it.ret);
            end
            checks++;
            if (cycles !== mon_it.cyc) begin
                errors++;
                $display("FAIL %s cycles: got %0d required %0d", mon_it.name, cycles,
                         mon_it.cyc);
            end
        end
    end

    initial begin
        v_fw  = ev(3'd0, 2'd0, 1, 0, 0, 0, 2'd0, 0, 2'd0, 2'd0, 0, 0, 3'd0);
        v_fd  = ev(3'd0, 2'd0, 1, 0, 1, 1, 2'd0, 0, 2'd0, 2'd0, 0, 0, 3'd0);
        v_dec = ev(3'd1, 2'd0, 0, 0, 0, 0, 2'd0, 0, 2'd0, 2'd0, 0, 0, 3'd0);
        @(posedge clk);
        #1;
        rstep("reset0");
        rstep("reset1");
        rst_n = 1'b1;

        // addu: 0,1,2,4 then FETCH
        load(6'b000000, 6'b100001);
        step("addu_fetch", 1, 0, v_fd, 0);
        step("addu_dec", 1, 1, v_dec, 0);
        step("addu_exec", 1, 1, ev(3'd2, 2'd0, 0, 0, 0, 0, 2'd0, 0, 2'd0, 2'd0, 0, 0, 3'd0), 0);
        step("addu_wb", 1, 0, ev(3'd4, 2'd0, 0, 0, 0, 0, 2'd0, 1, 2'd1, 2'd0, 0, 0, 3'd0), 1);

        // lw: 3 wait cycles in FETCH, 2 in MEM, 10 cycles total
        load(6'b100011, 6'b000000);
        for (int i = 0; i < 3; i++) step("lw_fetch_wait", 0, 1, v_fw, 0);
        step("lw_fetch", 1, 0, v_fd, 0);
        step("lw_dec", 0, 0, v_dec, 0);
        step("lw_exec", 1, 0, ev(3'd2, 2'd0, 0, 0, 0, 0, 2'd0, 0, 2'd0, 2'd0, 1, 1, 3'd0), 0);
        for (int i = 0; i < 2; i++)
            step("lw_mem_wait", 0, 0, ev(3'd3, 2'd0, 1, 0, 0, 0, 2'd0, 0, 2'd0, 2'd0, 0, 0, 3'd0), 0);
        step("lw_mem", 1, 0, ev(3'd3, 2'd0, 1, 0, 0, 0, 2'd0, 0, 2'd0, 2'd0, 0, 0, 3'd0), 0);
        step("lw_wb", 1, 0, ev(3'd4, 2'd0, 0, 0, 0, 0, 2'd0, 1, 2'd0, 2'd1, 0, 0, 3'd0), 1);

        // beq taken, then not taken
        load(6'b000100, 6'b000000);
        step("beq1_fetch", 1, 0, v_fd, 0);
        step("beq1_dec", 1, 1, v_dec, 0);
        step("beq1_exec", 1, 1, ev(3'd2, 2'd0, 0, 0, 0, 1, 2'd1, 0, 2'd0, 2'd0, 0, 0, 3'd1), 1);
        step("beq0_fetch", 1, 1, v_fd, 0);
        step("beq0_dec", 1, 1, v_dec, 0);
        step("beq0_exec", 1, 0, ev(3'd2, 2'd0, 0, 0, 0, 0, 2'd1, 0, 2'd0, 2'd0, 0, 0, 3'd1), 1);

        // jal and j finish in DECODE
        load(6'b000011, 6'b000000);
        step("jal_fetch", 1, 0, v_fd, 0);
        step("jal_dec", 1, 0, ev(3'd1, 2'd0, 0, 0, 0, 1, 2'd2, 1, 2'd2, 2'd2, 0, 0, 3'd0), 1);
        load(6'b000010, 6'b000000);
        step("j_fetch", 1, 0, v_fd, 0);
        step("j_dec", 1, 0, ev(3'd1, 2'd0, 0, 0, 0, 1, 2'd2, 0, 2'd0, 2'd0, 0, 0, 3'd0), 1);

        // ori, lui, subu, jr
        load(6'b001101, 6'b000000);
        step("ori_fetch", 1, 0, v_fd, 0);
        step("ori_dec", 1, 0, v_dec, 0);
        step("ori_exec", 1, 0, ev(3'd2, 2'd0, 0, 0, 0, 0, 2'd0, 0, 2'd0, 2'd0, 1, 0, 3'd2), 0);
        step("ori_wb", 1, 0, ev(3'd4, 2'd0, 0, 0, 0, 0, 2'd0, 1, 2'd0, 2'd0, 0, 0, 3'd0), 1);
        load(6'b001111, 6'b000000);
        step("lui_fetch", 1, 0, v_fd, 0);
        step("lui_dec", 1, 0, v_dec, 0);
        step("lui_exec", 1, 0, ev(3'd2, 2'd0, 0, 0, 0, 0, 2'd0, 0, 2'd0, 2'd0, 1, 0, 3'd3), 0);
        step("lui_wb", 1, 0, ev(3'd4, 2'd0, 0, 0, 0, 0, 2'd0, 1, 2'd0, 2'd0, 0, 0, 3'd0), 1);
        load(6'b000000, 6'b100011);
        step("subu_fetch", 1, 0, v_fd, 0);
        step("subu_dec", 1, 0, v_dec, 0);
        step("subu_exec", 1, 0, ev(3'd2, 2'd0, 0, 0, 0, 0, 2'd0, 0, 2'd0, 2'd0, 0, 0, 3'd1), 0);
        step("subu_wb", 1, 0, ev(3'd4, 2'd0, 0, 0, 0, 0, 2'd0, 1, 2'd1, 2'd0, 0, 0, 3'd0), 1);
        load(6'b000000, 6'b001000);
        step("jr_fetch", 1, 0, v_fd, 0);
        step("jr_dec", 1, 0, v_dec, 0);
        step("jr_exec", 1, 0, ev(3'd2, 2'd0, 0, 0, 0, 1, 2'd3, 0, 2'd0, 2'd0, 0, 0, 3'd0), 1);

        // sw: ready arrives on the 4th MEM cycle, just inside the timeout
        load(6'b101011, 6'b000000);
        step("sw_fetch", 1, 0, v_fd, 0);
        step("sw_dec", 1, 0, v_dec, 0);
        step("sw_exec", 1, 0, ev(3'd2, 2'd0, 0, 0, 0, 0, 2'd0, 0, 2'd0, 2'd0, 1, 1, 3'd0), 0);
        for (int i = 0; i < 3; i++)
            step("sw_mem_wait", 0, 0, ev(3'd3, 2'd0, 1, 1, 0, 0, 2'd0, 0, 2'd0, 2'd0, 0, 0, 3'd0), 0);
        step("sw_mem", 1, 0, ev(3'd3, 2'd0, 1, 1, 0, 0, 2'd0, 0, 2'd0, 2'd0, 0, 0, 3'd0), 1);

        // FETCH ready on the 4th cycle wins over the timeout
        load(6'b000000, 6'b100001);
        for (int i = 0; i < 3; i++) step("nearmiss_fetch_wait", 0, 0, v_fw, 0);
        step("nearmiss_fetch", 1, 0, v_fd, 0);
        step("nearmiss_dec", 1, 0, v_dec, 0);

        // reset mid-instruction aborts immediately
        rstep("abort_reset");
        rst_n = 1'b1;

        // illegal funct under R-type
        load(6'b000000, 6'b111111);
        step("badfn_fetch", 1, 0, v_fd, 0);
        step("badfn_dec", 1, 0, v_dec, 0);
        for (int i = 0; i < 3; i++)
            step("badfn_trap", 1, 1, ev(3'd7, 2'd1, 0, 0, 0, 0, 2'd0, 0, 2'd0, 2'd0, 0, 0, 3'd0), 0);
        rstep("badfn_reset");
        rst_n = 1'b1;

        // illegal opcode: sticky trap for 20 cycles with noisy inputs
        load(6'b111111, 6'b000000);
        step("badop_fetch", 1, 0, v_fd, 0);
        step("badop_dec", 1, 0, v_dec, 0);
        for (int i = 0; i < 20; i++)
            step("badop_trap", 1'($urandom), 1'($urandom),
                 ev(3'd7, 2'd1, 0, 0, 0, 0, 2'd0, 0, 2'd0, 2'd0, 0, 0, 3'd0), 0);
        rstep("badop_reset");
        rst_n = 1'b1;

        // FETCH timeout: fault 2 exactly 4 cycles after entry
        load(6'b000000, 6'b100001);
        for (int i = 0; i < 4; i++) step("tmo_fetch_wait", 0, 0, v_fw, 0);
        for (int i = 0; i < 3; i++)
            step("tmo_trap", 1, 0, ev(3'd7, 2'd2, 0, 0, 0, 0, 2'd0, 0, 2'd0, 2'd0, 0, 0, 3'd0), 0);
        rstep("tmo_reset");
        rst_n = 1'b1;
        step("post_reset_fetch", 1, 0, v_fd, 0);

        for (int i = 0; i < 10 && sb.size() > 0; i++) @(negedge clk);
        #1;
        checks++;
        if (sb.size() != 0) begin
            errors++;
            $display("FAIL drain: got %0d pending entries required 0", sb.size());
        end
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
